// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - decode-stage issue controller with load-use stall, halt and flush
module decode_issue_ctrl #(
   parameter int CNT_W = 16,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   input  logic [XLEN-1:0]  if_inst,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_ready,
   output logic [XLEN-1:0]  imm_inst,
   input  logic [XLEN-1:0]  imm_in,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_class,
   input  logic             flush,
   output logic             stall,
   output logic             halted,
   output logic [CNT_W-1:0] bubble_count
);

   localparam logic [2:0] CL_LOAD    = 3'd0;
   localparam logic [2:0] CL_OPIMM   = 3'd1;
   localparam logic [2:0] CL_STORE   = 3'd2;
   localparam logic [2:0] CL_BRANCH  = 3'd3;
   localparam logic [2:0] CL_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t          state;
   logic            id_valid;
   logic [XLEN-1:0] id_inst;
   logic [XLEN-1:0] id_pc;
   logic [2:0]      id_class;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            hazard;
   logic            advance;
   logic            accept;

   // Opcode classification of the held instruction; anything outside the four supported groups is illegal
   always_comb begin
      id_class = CL_ILLEGAL;
      if (id_inst[1:0] == 2'b11) begin
         case (id_inst[6:2])
            5'b00000: id_class = CL_LOAD;
            5'b00100: id_class = CL_OPIMM;
            5'b01000: id_class = CL_STORE;
            5'b11000: id_class = CL_BRANCH;
            default:  id_class = CL_ILLEGAL;
         endcase
      end
      uses_rs1 = (id_class != CL_ILLEGAL);
      uses_rs2 = (id_class == CL_STORE) || (id_class == CL_BRANCH);
   end

   assign hazard = id_valid && ex_valid && (ex_class == CL_LOAD) && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (id_inst[19:15] == ex_rd)) ||
                    (uses_rs2 && (id_inst[24:20] == ex_rd)));

   assign advance  = id_valid && !hazard && (!ex_valid || ex_ready) &&
                     (state != ST_HALT) && !flush;
   assign if_ready = !flush && (state != ST_HALT) && (!id_valid || advance);
   assign accept   = if_valid && if_ready;
   assign imm_inst = id_inst;

   // IF/ID register: load on accepted fetch, empty on advance or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid <= 1'b0;
         id_inst  <= '0;
         id_pc    <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (accept) begin
         id_valid <= 1'b1;
         id_inst  <= if_inst;
         id_pc    <= if_pc;
      end else if (advance) begin
         id_valid <= 1'b0;
      end
   end

   // ID/EX register: replaced on advance, drained to a bubble when consumed with nothing behind it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_pc    <= '0;
         ex_imm   <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
         ex_class <= CL_LOAD;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (advance) begin
         ex_valid <= 1'b1;
         ex_pc    <= id_pc;
         ex_imm   <= (id_class == CL_ILLEGAL) ? '0 : imm_in;
         ex_rs1   <= id_inst[19:15];
         ex_rs2   <= id_inst[24:20];
         ex_rd    <= id_inst[11:7];
         ex_class <= id_class;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

   // Control FSM with registered status flags and the saturating bubble counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         stall        <= 1'b0;
         halted       <= 1'b0;
         bubble_count <= '0;
      end else if (flush) begin
         state  <= ST_RUN;
         stall  <= 1'b0;
         halted <= 1'b0;
      end else begin
         if ((state == ST_STALL) && ex_ready && (bubble_count != '1))
            bubble_count <= bubble_count + CNT_W'(1);
         if (state != ST_HALT) begin
            if (advance && (id_class == CL_ILLEGAL)) begin
               state  <= ST_HALT;
               stall  <= 1'b0;
               halted <= 1'b1;
            end else if (hazard) begin
               state  <= ST_STALL;
               stall  <= 1'b1;
               halted <= 1'b0;
            end else begin
               state  <= ST_RUN;
               stall  <= 1'b0;
               halted <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - scoreboard testbench for decode_issue_ctrl
module tb_decode_issue_ctrl;

   localparam int CNT_W = 16;
   localparam int XLEN  = 32;

   localparam logic [31:0] I_LW    = 32'h0080A283;
   localparam logic [31:0] I_ADDI1 = 32'h00128313;
   localparam logic [31:0] I_SW    = 32'hFE21AE23;
   localparam logic [31:0] I_BEQ   = 32'hFE000CE3;
   localparam logic [31:0] I_ADDI5 = 32'h00500093;
   localparam logic [31:0] I_ILL   = 32'h00000033;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             if_valid;
   logic [XLEN-1:0]  if_inst;
   logic [XLEN-1:0]  if_pc;
   logic             if_ready;
   logic [XLEN-1:0]  imm_inst;
   logic [XLEN-1:0]  imm_in;
   logic             ex_valid;
   logic             ex_ready;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_imm;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic [2:0]       ex_class;
   logic             flush;
   logic             stall;
   logic             halted;
   logic [CNT_W-1:0] bubble_count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  cls;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   decode_issue_ctrl #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
      .imm_inst(imm_inst), .imm_in(imm_in),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_class(ex_class), .flush(flush), .stall(stall), .halted(halted),
      .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   // Immediate generator model; unknown formats return a marker so forced-zero immediates are visible
   function automatic logic [31:0] gen_imm(input logic [31:0] i);
      case (i[6:2])
         5'b00000, 5'b00100: gen_imm = {{20{i[31]}}, i[31:20]};
         5'b01000:           gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
         5'b11000:           gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default:            gen_imm = 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb imm_in = gen_imm(imm_inst);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] cls);
      exp_t e;
      e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.cls = cls;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction and return just after the edge that accepts it
   task automatic feed(input logic [31:0] inst, input logic [31:0] pc);
      logic acc;
      acc = 1'b0;
      if_valid = 1'b1;
      if_inst  = inst;
      if_pc    = pc;
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk);
         acc = if_ready;
         cyc();
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL feed_timeout actual=not_accepted expected=accepted pc=%h", pc);
      end
   endtask

   // Monitor: every op consumed by execute must match the head of the scoreboard
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(negedge clk);
         if (rst_n && ex_valid && ex_ready && !flush) begin
            got = {ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_class};
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected actual_pc=%h expected=no_op", ex_pc);
            end else begin
               e = sb.pop_front();
               if (got !== e) begin
                  failures++;
                  $display("FAIL sb_op actual pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d cls=%0d expected pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d cls=%0d",
                           got.pc, got.imm, got.rs1, got.rs2, got.rd, got.cls,
                           e.pc, e.imm, e.rs1, e.rs2, e.rd, e.cls);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_ready = 1'b0; flush = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_stall", stall, 0);
      chk("rst_halted", halted, 0);
      chk("rst_if_ready", if_ready, 1);
      chk("rst_bubbles", bubble_count, 0);
      chk("rst_ex_pc", ex_pc, 0);
      chk("rst_ex_class", ex_class, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // load-use bubble
      ex_ready = 1'b1;
      push(32'h100, 32'd8, 5'd1, 5'd8, 5'd5, 3'd0);
      push(32'h104, 32'd1, 5'd5, 5'd1, 5'd6, 3'd1);
      feed(I_LW, 32'h100);
      feed(I_ADDI1, 32'h104);
      if_valid = 1'b0;
      @(negedge clk);
      chk("lu_ex_class", ex_class, 0);
      chk("lu_ex_imm", ex_imm, 8);
      chk("lu_if_ready_hazard", if_ready, 0);
      chk("lu_stall_pre", stall, 0);
      cyc();
      @(negedge clk);
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_stall", stall, 1);
      chk("lu_bubbles_pre", bubble_count, 0);
      cyc();
      @(negedge clk);
      chk("lu_issue_valid", ex_valid, 1);
      chk("lu_bubbles", bubble_count, 1);
      chk("lu_stall_post", stall, 0);
      repeat (2) cyc();

      // store then branch, back to back
      push(32'h200, 32'hFFFF_FFFC, 5'd3, 5'd2, 5'd28, 3'd2);
      push(32'h204, 32'hFFFF_FFF8, 5'd0, 5'd0, 5'd25, 3'd3);
      feed(I_SW, 32'h200);
      feed(I_BEQ, 32'h204);
      if_valid = 1'b0;
      @(negedge clk);
      chk("sb_no_stall_store", stall, 0);
      chk("sb_if_ready", if_ready, 1);
      cyc();
      @(negedge clk);
      chk("sb_beq_valid", ex_valid, 1);
      chk("sb_beq_class", ex_class, 3);
      repeat (2) cyc();

      // backpressure
      ex_ready = 1'b0;
      push(32'h300, 32'd5, 5'd0, 5'd5, 5'd1, 3'd1);
      push(32'h304, 32'hFFFF_FFFC, 5'd3, 5'd2, 5'd28, 3'd2);
      feed(I_ADDI5, 32'h300);
      feed(I_SW, 32'h304);
      if_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", ex_valid, 1);
         chk("bp_pc", ex_pc, 32'h300);
         chk("bp_imm", ex_imm, 5);
         chk("bp_rd", ex_rd, 1);
         chk("bp_if_ready", if_ready, 0);
         cyc();
      end
      ex_ready = 1'b1;
      cyc();
      @(negedge clk);
      chk("bp_second_pc", ex_pc, 32'h304);
      chk("bp_second_valid", ex_valid, 1);
      repeat (2) cyc();

      // flush while stalled on a held load
      ex_ready = 1'b0;
      feed(I_LW, 32'h400);
      feed(I_ADDI1, 32'h404);
      if_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("fs_stall", stall, 1);
      chk("fs_bubbles_pre", bubble_count, 1);
      flush = 1'b1;
      ex_ready = 1'b1;
      cyc();
      flush = 1'b0;
      @(negedge clk);
      chk("fs_ex_valid", ex_valid, 0);
      chk("fs_stall_post", stall, 0);
      chk("fs_bubbles", bubble_count, 1);
      chk("fs_if_ready", if_ready, 1);
      cyc();
      @(negedge clk);
      chk("fs_id_empty", ex_valid, 0);
      cyc();

      // illegal opcode halts until flush
      push(32'h500, 32'd0, 5'd0, 5'd0, 5'd0, 3'd7);
      feed(I_ILL, 32'h500);
      if_valid = 1'b0;
      cyc();
      if_valid = 1'b1; if_inst = I_ADDI5; if_pc = 32'h510;
      @(negedge clk);
      chk("il_class", ex_class, 7);
      chk("il_imm", ex_imm, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("il_halted", halted, 1);
         chk("il_if_ready", if_ready, 0);
         cyc();
      end
      flush = 1'b1;
      if_valid = 1'b0;
      cyc();
      flush = 1'b0;
      @(negedge clk);
      chk("il_halted_post", halted, 0);
      chk("il_ex_valid_post", ex_valid, 0);
      chk("il_if_ready_post", if_ready, 1);
      cyc();

      // asynchronous reset mid-stream
      ex_ready = 1'b0;
      feed(I_ADDI5, 32'h600);
      if_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("ar_pre_valid", ex_valid, 1);
      chk("ar_pre_bubbles", bubble_count, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ex_valid", ex_valid, 0);
      chk("ar_bubbles", bubble_count, 0);
      chk("ar_ex_pc", ex_pc, 0);
      chk("ar_ex_imm", ex_imm, 0);
      chk("ar_ex_rd", ex_rd, 0);
      chk("ar_ex_rs2", ex_rs2, 0);
      chk("ar_if_ready", if_ready, 1);
      cyc();
      rst_n = 1'b1;
      ex_ready = 1'b1;
      @(negedge clk);
      chk("ar_post_valid", ex_valid, 0);

      // recovery after reset
      cyc();
      push(32'h700, 32'hFFFF_FFF8, 5'd0, 5'd0, 5'd25, 3'd3);
      feed(I_BEQ, 32'h700);
      if_valid = 1'b0;
      repeat (3) cyc();
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Decode-stage controller between fetch and execute in the pipelined core.
- Holds the IF/ID instruction register and drives the immediate generator with the held instruction.
- Classifies the opcode and captures the returned immediate into the ID/EX register.
- Enforces valid/ready handshakes on both sides, inserts load-use bubbles, halts on unsupported opcodes and honours branch flushes.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.
- XLEN, 32, instruction, PC and immediate width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch offers an instruction.
- if_inst  in  XLEN  offered instruction.
- if_pc  in  XLEN  offered PC.
- if_ready  out  1  controller accepts the offer this cycle.
- imm_inst  out  XLEN  instruction driven to the immediate generator; equals id_inst combinationally.
- imm_in  in  XLEN  immediate returned by the immediate generator, same cycle.
- ex_valid  out  1  ID/EX register holds a valid op.
- ex_ready  in  1  execute consumes the op this cycle.
- ex_pc, ex_imm  out  XLEN  registered PC and immediate.
- ex_rs1, ex_rs2, ex_rd  out  5  inst[19:15], inst[24:20], inst[11:7].
- ex_class  out  3  0=LOAD, 1=OPIMM, 2=STORE, 3=BRANCH, 7=ILLEGAL.
- flush  in  1  branch redirect; kills the ID and EX contents.
- stall  out  1  high while a load-use bubble is being inserted.
- halted  out  1  FSM is in HALT.
- bubble_count  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (async, rst_n=0): id_valid=0, ex_valid=0, ex_pc=0, ex_imm=0, ex_rs1=0, ex_rs2=0, ex_rd=0, ex_class=0, bubble_count=0, FSM=RUN.
  - Combinational outputs during reset: stall=0, halted=0, if_ready=1.
  - Reset mid-transfer discards all held instructions.
- Classification uses inst[6:2] and requires inst[1:0]=11.
  - 00000 is LOAD, 00100 is OPIMM, 01000 is STORE, 11000 is BRANCH.
  - Any other value is ILLEGAL.
  - uses_rs1 for every non-illegal class; uses_rs2 for STORE and BRANCH only.
- hazard = id_valid & ex_valid & ex_class==LOAD & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- advance = id_valid & !hazard & (!ex_valid | ex_ready) & FSM!=HALT & !flush.
- if_ready = !flush & FSM!=HALT & (!id_valid | advance).
- On an accepted fetch, id_inst/id_pc load at the edge and id_valid=1.
  - Otherwise, id_valid clears on advance.
- On advance, the EX register loads id fields and class.
  - ex_imm=imm_in, or 0 when the class is ILLEGAL.
  - ex_valid=1.
- If ex_ready and no advance, ex_valid clears (bubble); other EX fields hold.
- If ex_valid & !ex_ready, every EX output holds stable.
- Latency: an instruction accepted at edge N appears on ex_* at edge N+1 when unstalled; throughput is 1 per cycle.
- FSM:
  - RUN to STALL when hazard=1. Each cycle in STALL with ex_ready=1 inserts one bubble and increments bubble_count, which saturates at all-ones.
  - STALL to RUN when hazard clears.
  - RUN or STALL to HALT when an ILLEGAL op advances into EX.
  - HALT: no accepts, no advances; EX still drains via ex_ready.
  - Any state to RUN on flush.
- stall=(FSM==STALL); halted=(FSM==HALT).
- Flush has top priority: at the next edge id_valid=0, ex_valid=0, FSM=RUN. Fetch is not accepted in the flush cycle; bubble_count is not incremented.
- Simultaneous ex_ready and advance: the EX register is replaced with the new op with no bubble.

Test Plan:
- Load-use: feed 0x0080A283 (lw x5,8(x1)), then 0x00128313 (addi x6,x5,1), ex_ready=1 -> lw on ex_* with ex_imm=8, class 0. One cycle later ex_valid=0 and stall=1. Next cycle addi is issued with ex_imm=1, class 1; bubble_count=1.
- Store and branch immediates: 0xFE21AE23 (sw x2,-4(x3)) -> ex_imm=0xFFFFFFFC, class 2, rs1=3, rs2=2. Then 0xFE000CE3 (beq x0,x0,-8) -> ex_imm=0xFFFFFFF8, class 3, with no stall since ex_rd for the store is not a load.
- Illegal: 0x00000033 -> ex_class=7, ex_imm=0, halted=1, if_ready=0 for 10 cycles. flush=1 for one cycle -> halted=0, ex_valid=0, and if_ready=1 on the following cycle.
- Backpressure: ex_ready=0 for 5 cycles with addi 0x00500093 held in EX and a second op in ID -> ex_* stable and if_ready=0. Releasing ex_ready issues the second op on the next edge.
- Flush during stall: hazard present and flush=1 -> ID and EX are both empty next cycle, stall=0, and bubble_count is unchanged.
- Async reset mid-stream: rst_n low between edges -> ex_valid=0, bubble_count=0 and all registered outputs 0 immediately, without waiting for a clk edge.
